// File: rtl/fifo_sync_param.sv
`default_nettype none
// ============================================================================
// Module      : fifo_sync_param
// Description : Single-clock FIFO with parametrised width and depth for the
//               audio sample path. Provides a fill-level count, programmable
//               almost-full / almost-empty marks and sticky overflow /
//               underflow flags with a synchronous clear.
// Optional    : FIFO_FWFT_EN - when defined, data_out shows the head word
//               combinationally (first-word-fall-through) and rd pops it.
//               When undefined, data_out is registered and updates on the
//               edge that accepts a read (1-cycle rd->data_out latency).
// Ports       : clk            rising-edge system clock
//               rst_n          asynchronous active-low reset
//               wr / data_in   write request and write data
//               rd / data_out  read request and read data
//               clr_err        synchronous clear of the sticky error flags
//               count          words stored, 0..DEPTH (AW+1 bits)
//               fifo_full / fifo_empty / almost_full / almost_empty
//               fifo_overflow / fifo_underflow  sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module fifo_sync_param #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 32,
    parameter int AF_MARGIN = 4,
    parameter int AE_MARGIN = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr,
    input  logic [DATA_W-1:0]          data_in,
    input  logic                       rd,
    output logic [DATA_W-1:0]          data_out,
    input  logic                       clr_err,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic                       fifo_overflow,
    output logic                       fifo_underflow
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE  = (AW+1)'(1);
    localparam logic [AW:0] AF_LEVEL = (AW+1)'(DEPTH - AF_MARGIN);
    localparam logic [AW:0] AE_LEVEL = (AW+1)'(AE_MARGIN);

    // Storage array; intentionally not reset.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    logic [AW:0] count_q, count_d;
    logic        ovf_q, ovf_d;
    logic        udf_q, udf_d;

    logic        full;
    logic        empty;
    logic        we;
    logic        re;

    // Pointers carry one extra wrap bit: equal indices with differing wrap
    // bits means the FIFO holds exactly DEPTH words.
    assign full  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty = (wptr_q == rptr_q);

    // A write while full is still accepted when a read frees a slot in the
    // same cycle; a read while empty is never accepted.
    assign we = wr && (!full || rd);
    assign re = rd && !empty;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        ovf_d   = ovf_q && !clr_err;
        udf_d   = udf_q && !clr_err;

        if (we) wptr_d = wptr_q + PTR_ONE;
        if (re) rptr_d = rptr_q + PTR_ONE;

        case ({we, re})
            2'b10:   count_d = count_q + PTR_ONE;
            2'b01:   count_d = count_q - PTR_ONE;
            default: count_d = count_q;
        endcase

        // A fresh error takes priority over a concurrent clear.
        if (wr && full && !rd) ovf_d = 1'b1;
        if (rd && empty)       udf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Memory write port. When full with a simultaneous read, the write lands
    // in the slot being read; the read still returns the old word because
    // both sample the array before the edge.
    always_ff @(posedge clk) begin
        if (we) mem[wptr_q[AW-1:0]] <= data_in;
    end

`ifdef FIFO_FWFT_EN
    // Head word is visible whenever the FIFO holds data; zero while empty.
    assign data_out = empty ? '0 : mem[rptr_q[AW-1:0]];
`else
    logic [DATA_W-1:0] data_out_q, data_out_d;

    // Registered read: update only on an accepted read, otherwise hold.
    always_comb begin
        data_out_d = data_out_q;
        if (re) data_out_d = mem[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_out_q <= '0;
        else        data_out_q <= data_out_d;
    end

    assign data_out = data_out_q;
`endif

    assign count          = count_q;
    assign fifo_full      = full;
    assign fifo_empty     = empty;
    assign almost_full    = (count_q >= AF_LEVEL);
    assign almost_empty   = (count_q <= AE_LEVEL);
    assign fifo_overflow  = ovf_q;
    assign fifo_underflow = udf_q;

endmodule
`default_nettype wire
